slot_scheduler: RTL
===================

// Module: slot_scheduler
// PURPOSE
//  Time-slot arbiter sharing one resource among 4 requesters. A free-running
//  3-bit slot counter is decoded by a fixed slot map into a slot owner. The
//  owner has priority in its slot; otherwise grants fall back round-robin.
//  Grants are held until the requester finishes or a burst limit preempts it.
//  Sits in front of any shared datapath port sequenced by a wrapping counter.
// PARAMETERS
//  MAX_BURST  4  max consecutive grant cycles per grant; 0 = unlimited
// PORTS
//  clock       in   1  global clock, all state updates on posedge
//  reset       in   1  synchronous, active-high
//  req         in   4  request per requester, level-sensitive
//  done        in   4  requester i finished; only done[gnt_id] is honoured
//  gnt         out  4  one-hot grant, registered
//  gnt_id      out  2  index of granted requester, valid when gnt_valid
//  gnt_valid   out  1  |gnt
//  preempt     out  1  1-cycle pulse: grant ended by burst limit
//  slot        out  3  current slot counter value
//  slot_owner  out  2  decoded owner of current slot
// BEHAVIOUR
//  Reset: slot=0, gnt=0, gnt_id=0, gnt_valid=0, preempt=0, state=IDLE,
//    last_id=3 (RR starts at 0), beat=0. Reset mid-grant drops gnt next edge.
//  Slot: +1 every cycle regardless of state, wraps 7->0.
//  Slot map (case with fallthrough): 0,1,2 -> 0; 3 -> 1; 4,5 -> 2; else -> 3.
//  States: IDLE, GRANT.
//  IDLE: if req==0 stay. Else winner = slot_owner if req[slot_owner], else
//    first set req scanning last_id+1, +2, +3, +4 (mod 4). Next edge: gnt=
//    onehot(winner), gnt_id=winner, last_id=winner, beat=1, ->GRANT.
//    Latency: req sampled at edge k -> gnt visible after edge k (1 cycle).
//  GRANT, per edge, first match wins:
//    done[gnt_id]=1           -> release, preempt=0
//    req[gnt_id]=0            -> release (abandon), preempt=0
//    MAX_BURST!=0 && beat==MAX_BURST -> release, preempt=1 for one cycle
//    else hold, beat+=1 (saturating; width $clog2(MAX_BURST+1), min 1)
//  Release: gnt=0, gnt_valid=0, beat=0, ->IDLE. IDLE always lasts >=1 cycle
//    (one bubble between grants); no back-to-back grants.
//  done on non-granted lines and while IDLE: ignored.
//  Preempted requester keeps req high: re-eligible next arbitration, but RR
//    pointer (last_id) already moved past it, so others win first if pending.
//  Outputs change only on clock edges; gnt is never multi-hot.
// TESTING
//  1 Reset 2 cycles, release at slot=0 with req=0010 -> gnt=0010 after 1st
//    edge, gnt_id=1, slot_owner during decision=0.
//  2 Hold req=1111 until slot=3, IDLE -> gnt=0010 (owner 1 wins over RR).
//  3 req=0100 held, done=0, MAX_BURST=4 -> gnt high exactly 4 cycles,
//    preempt=1 in cycle after last grant cycle, gnt=0 one cycle, regrant 0100.
//  4 done[2]=1 on beat 4 with MAX_BURST=4 -> release, preempt stays 0.
//  5 req=1001 at slot 4 (owner 2 idle), last_id=0 -> gnt=1000; after release
//    with req=1001 at slot 6 (owner 3) -> gnt=1000 again (owner priority).
//  6 reset asserted during GRANT -> gnt=0, slot=0, preempt=0 after that edge;
//    with req=0001, first grant one cycle after reset deasserts.

Source files
------------

// File: rtl/slot_scheduler.sv
// slot_scheduler: time-slot arbiter sharing one resource among four requesters.
// A wrapping 3-bit slot counter is mapped to a slot owner. The owner wins
// arbitration in its slot; otherwise a round-robin scan picks the winner.
// A grant is held until the requester finishes, drops its request, or hits
// the burst limit. There is always at least one idle cycle between grants.
module slot_scheduler #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic [3:0] done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       preempt,
    output logic [2:0] slot,
    output logic [1:0] slot_owner
);

    // Beat counter wide enough to hold MAX_BURST, never narrower than 1 bit.
    localparam int BEAT_W = ($clog2(MAX_BURST + 1) < 1) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [BEAT_W-1:0] BEAT_LIMIT = BEAT_W'(MAX_BURST);
    localparam logic [BEAT_W-1:0] BEAT_ONE   = BEAT_W'(1);
    localparam logic [BEAT_W-1:0] BEAT_SAT   = {BEAT_W{1'b1}};

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        slot_q;
    logic [3:0]        gnt_q, gnt_d;
    logic [1:0]        gntId_q, gntId_d;
    logic [1:0]        lastId_q, lastId_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              preempt_q, preempt_d;

    logic [1:0]        ownerId;
    logic [1:0]        rrWinner;
    logic [1:0]        winner;
    logic [1:0]        scanIdx;
    logic              rrHit;

    // Fixed slot map: slots 0-2 belong to requester 0, slot 3 to 1,
    // slots 4-5 to 2, and the remaining slots to 3.
    always_comb begin
        ownerId = 2'd3;
        case (slot_q)
            3'd0, 3'd1, 3'd2: ownerId = 2'd0;
            3'd3:             ownerId = 2'd1;
            3'd4, 3'd5:       ownerId = 2'd2;
            default:          ownerId = 2'd3;
        endcase
    end

    // Round-robin scan starting just after the last winner; the fourth step
    // wraps back to the last winner itself so a lone requester can win again.
    always_comb begin
        rrHit    = 1'b0;
        rrWinner = 2'd0;
        scanIdx  = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            scanIdx = lastId_q + 2'(k);
            if (!rrHit && req[scanIdx]) begin
                rrHit    = 1'b1;
                rrWinner = scanIdx;
            end
        end
        winner = req[ownerId] ? ownerId : rrWinner;
    end

    // Next-state logic: arbitration in IDLE, hold/release decisions in GRANT.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gntId_d   = gntId_q;
        lastId_d  = lastId_q;
        beat_d    = beat_q;
        preempt_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req != 4'b0000) begin
                    gnt_d    = 4'b0001 << winner;
                    gntId_d  = winner;
                    lastId_d = winner;
                    beat_d   = BEAT_ONE;
                    state_d  = GRANT;
                end
            end
            GRANT: begin
                if (done[gntId_q] || !req[gntId_q]) begin
                    gnt_d   = 4'b0000;
                    beat_d  = '0;
                    state_d = IDLE;
                end else if ((MAX_BURST != 0) && (beat_q == BEAT_LIMIT)) begin
                    gnt_d     = 4'b0000;
                    beat_d    = '0;
                    preempt_d = 1'b1;
                    state_d   = IDLE;
                end else if (beat_q != BEAT_SAT) begin
                    beat_d = beat_q + BEAT_ONE;
                end
            end
            default: begin
                gnt_d   = 4'b0000;
                beat_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State registers; the slot counter free-runs whatever the arbiter does.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            slot_q    <= 3'd0;
            gnt_q     <= 4'b0000;
            gntId_q   <= 2'd0;
            lastId_q  <= 2'd3;
            beat_q    <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_q + 3'd1;
            gnt_q     <= gnt_d;
            gntId_q   <= gntId_d;
            lastId_q  <= lastId_d;
            beat_q    <= beat_d;
            preempt_q <= preempt_d;
        end
    end

    assign gnt        = gnt_q;
    assign gnt_id     = gntId_q;
    assign gnt_valid  = |gnt_q;
    assign preempt    = preempt_q;
    assign slot       = slot_q;
    assign slot_owner = ownerId;

endmodule
